// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU result path: status-flag bit
//            positions, supported op-code constants, the illegal-op check and
//            the packed FIFO entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Bit positions inside a packed 4-bit flag vector {cout,neg,zero,ovf}
  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  // Op-code constants for the ALU select field, 0000 to 1101.
  // 1001 sits inside that range but is reserved and flagged as illegal.
  localparam logic [3:0] OP_SEL_0  = 4'b0000;
  localparam logic [3:0] OP_SEL_1  = 4'b0001;
  localparam logic [3:0] OP_SEL_2  = 4'b0010;
  localparam logic [3:0] OP_SEL_3  = 4'b0011;
  localparam logic [3:0] OP_SEL_4  = 4'b0100;
  localparam logic [3:0] OP_SEL_5  = 4'b0101;
  localparam logic [3:0] OP_SEL_6  = 4'b0110;
  localparam logic [3:0] OP_SEL_7  = 4'b0111;
  localparam logic [3:0] OP_SEL_8  = 4'b1000;
  localparam logic [3:0] OP_SEL_9  = 4'b1001;
  localparam logic [3:0] OP_SEL_10 = 4'b1010;
  localparam logic [3:0] OP_SEL_11 = 4'b1011;
  localparam logic [3:0] OP_SEL_12 = 4'b1100;
  localparam logic [3:0] OP_SEL_13 = 4'b1101;

  // Select codes the ALU does not implement
  function automatic logic is_illegal_sel(input logic [3:0] sel);
    return (sel == 4'b1001) || (sel == 4'b1110) || (sel == 4'b1111);
  endfunction

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  sel;
    logic [3:0]  flags;
    logic        illegal;
  } alu_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : alu_fifo_mem
// Purpose  : DEPTH x alu_entry_t register array, one synchronous write port
//            and one asynchronous (combinational) read port. Not reset.
// Ports    : clk      - clock
//            wr_en    - write enable
//            wr_addr  - write index
//            wr_data  - entry to store
//            rd_addr  - read index
//            rd_data  - entry at rd_addr (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module alu_fifo_mem
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  alu_entry_t    wr_data,
  input  logic [AW-1:0] rd_addr,
  output alu_entry_t    rd_data
);

  alu_entry_t mem_q [DEPTH];
  alu_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Purpose  : Registered output stage behind the 32-bit ALU. Captures Y, the
//            op select and the {cout,neg,zero,ovf} flags through valid/ready,
//            buffers up to DEPTH results in order (show-ahead head) and keeps
//            the flags of the most recently accepted result.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            in_valid/in_ready          - upstream handshake (ready = not full)
//            in_y, in_sel, in_cout,
//            in_neg, in_zero, in_ovf    - ALU result and flags
//            out_valid/out_ready        - downstream handshake
//            out_y, out_sel, out_flags,
//            out_illegal                - head entry (zero while empty)
//            last_flags                 - flags of last accepted entry
//            count                      - occupancy
//            clr_sticky, sticky_ovf     - only with ALU_STICKY_OVF_EN
// Options  : ALU_STICKY_OVF_EN adds a sticky overflow bit with clear input.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_y,
  input  logic [3:0]  in_sel,
  input  logic        in_cout,
  input  logic        in_neg,
  input  logic        in_zero,
  input  logic        in_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [3:0]  out_sel,
  output logic [3:0]  out_flags,
  output logic        out_illegal,
  output logic [3:0]  last_flags,
`ifdef ALU_STICKY_OVF_EN
  input  logic        clr_sticky,
  output logic        sticky_ovf,
`endif
  output logic [AW:0] count
);

  localparam int            CW       = AW + 1;
  localparam logic [AW:0]   FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    last_flags_q, last_flags_d;

  logic          push;
  logic          pop;
  logic [3:0]    in_flags;
  alu_entry_t    wr_entry;
  alu_entry_t    head;

  // Ready and valid come only from the registered count, so there is no
  // combinational path from out_ready to in_ready: a full FIFO stays closed
  // for the cycle in which it is popped.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_flags            = '0;
    in_flags[FLAG_COUT] = in_cout;
    in_flags[FLAG_NEG]  = in_neg;
    in_flags[FLAG_ZERO] = in_zero;
    in_flags[FLAG_OVF]  = in_ovf;
  end

  always_comb begin
    wr_entry.y       = in_y;
    wr_entry.sel     = in_sel;
    wr_entry.flags   = in_flags;
    wr_entry.illegal = is_illegal_sel(in_sel);
  end

  alu_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_flags_d = last_flags_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + AW'(1);
      last_flags_d = in_flags;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_flags_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_flags_q <= last_flags_d;
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign out_y       = out_valid ? head.y       : '0;
  assign out_sel     = out_valid ? head.sel     : '0;
  assign out_flags   = out_valid ? head.flags   : '0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;
  assign last_flags  = last_flags_q;
  assign count       = count_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_ovf_q, sticky_ovf_d;

  // Set has priority over clear when both happen in one cycle.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    if (clr_sticky) begin
      sticky_ovf_d = 1'b0;
    end
    if (push && in_ovf) begin
      sticky_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_fifo
// Purpose  : Self-checking bench for alu_result_fifo: a directed vector table,
//            hand-written multi-cycle sequences (pointer wrap, async reset,
//            sticky overflow) and a randomized run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic [3:0]  in_sel;
  logic        in_cout, in_neg, in_zero, in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_sel;
  logic [3:0]  out_flags;
  logic        out_illegal;
  logic [3:0]  last_flags;
  logic [2:0]  count;
  logic        clr_sticky;
  logic        sticky_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_y        (in_y),
    .in_sel      (in_sel),
    .in_cout     (in_cout),
    .in_neg      (in_neg),
    .in_zero     (in_zero),
    .in_ovf      (in_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_sel     (out_sel),
    .out_flags   (out_flags),
    .out_illegal (out_illegal),
    .last_flags  (last_flags),
`ifdef ALU_STICKY_OVF_EN
    .clr_sticky  (clr_sticky),
    .sticky_ovf  (sticky_ovf),
`endif
    .count       (count)
  );

`ifndef ALU_STICKY_OVF_EN
  assign sticky_ovf = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] y, input logic [3:0] sel,
                       input logic [3:0] fl, input logic ordy, input logic clr);
    in_valid   = iv;
    in_y       = y;
    in_sel     = sel;
    in_cout    = fl[3];
    in_neg     = fl[2];
    in_zero    = fl[1];
    in_ovf     = fl[0];
    out_ready  = ordy;
    clr_sticky = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Directed vector table
  typedef struct {
    logic        iv;
    logic [31:0] y;
    logic [3:0]  sel;
    logic [3:0]  fl;
    logic        ordy;
    int          cnt;
    logic        ov;
    logic [31:0] oy;
    logic [3:0]  of;
    logic        ill;
    logic [3:0]  lf;
  } vec_t;

  vec_t tbl [16];

  // Behavioural reference model
  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  sel;
    logic [3:0]  fl;
  } m_t;

  m_t         mq [$];
  logic [3:0] lf_m;
  logic       st_m;

  task automatic check_model();
    m_t h;
    chk("rnd_count", 32'(count), 32'(mq.size()));
    chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("rnd_out_y", out_y, h.y);
      chk("rnd_out_sel", 32'(out_sel), 32'(h.sel));
      chk("rnd_out_flags", 32'(out_flags), 32'(h.fl));
      chk("rnd_out_illegal", 32'(out_illegal), 32'(h.sel inside {4'b1001, 4'b1110, 4'b1111}));
    end else begin
      chk("rnd_out_y_empty", out_y, 32'h0);
      chk("rnd_out_sel_empty", 32'(out_sel), 32'h0);
      chk("rnd_out_flags_empty", 32'(out_flags), 32'h0);
      chk("rnd_out_illegal_empty", 32'(out_illegal), 32'h0);
    end
    chk("rnd_last_flags", 32'(last_flags), 32'(lf_m));
`ifdef ALU_STICKY_OVF_EN
    chk("rnd_sticky_ovf", 32'(sticky_ovf), 32'(st_m));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              iv   y      sel      fl       ordy cnt ov  oy     of       ill  lf
    tbl[0]  = '{1'b1, 32'h5, 4'b0110, 4'b0000, 1'b0, 1, 1'b1, 32'h5, 4'b0000, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 0, 1'b0, 32'h0, 4'b0000, 1'b0, 4'b0000};
    tbl[2]  = '{1'b1, 32'h1, 4'b0000, 4'b1000, 1'b0, 1, 1'b1, 32'h1, 4'b1000, 1'b0, 4'b1000};
    tbl[3]  = '{1'b1, 32'h2, 4'b0001, 4'b0100, 1'b0, 2, 1'b1, 32'h1, 4'b1000, 1'b0, 4'b0100};
    tbl[4]  = '{1'b1, 32'h3, 4'b0010, 4'b0010, 1'b0, 3, 1'b1, 32'h1, 4'b1000, 1'b0, 4'b0010};
    tbl[5]  = '{1'b1, 32'h4, 4'b0011, 4'b0001, 1'b0, 4, 1'b1, 32'h1, 4'b1000, 1'b0, 4'b0001};
    tbl[6]  = '{1'b1, 32'h5, 4'b0100, 4'b1111, 1'b0, 4, 1'b1, 32'h1, 4'b1000, 1'b0, 4'b0001};
    tbl[7]  = '{1'b1, 32'h5, 4'b0100, 4'b1111, 1'b1, 3, 1'b1, 32'h2, 4'b0100, 1'b0, 4'b0001};
    tbl[8]  = '{1'b1, 32'h5, 4'b0101, 4'b0011, 1'b0, 4, 1'b1, 32'h2, 4'b0100, 1'b0, 4'b0011};
    tbl[9]  = '{1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 3, 1'b1, 32'h3, 4'b0010, 1'b0, 4'b0011};
    tbl[10] = '{1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 2, 1'b1, 32'h4, 4'b0001, 1'b0, 4'b0011};
    tbl[11] = '{1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 1, 1'b1, 32'h5, 4'b0011, 1'b0, 4'b0011};
    tbl[12] = '{1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 0, 1'b0, 32'h0, 4'b0000, 1'b0, 4'b0011};
    tbl[13] = '{1'b1, 32'hA, 4'b1001, 4'b0101, 1'b0, 1, 1'b1, 32'hA, 4'b0101, 1'b1, 4'b0101};
    tbl[14] = '{1'b1, 32'hB, 4'b1101, 4'b1010, 1'b1, 1, 1'b1, 32'hB, 4'b1010, 1'b0, 4'b1010};
    tbl[15] = '{1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 0, 1'b0, 32'h0, 4'b0000, 1'b0, 4'b1010};

    // Reset state, sampled while reset is held
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_last_flags", 32'(last_flags), 32'h0);
    chk("reset_out_y", out_y, 32'h0);
    chk("reset_out_illegal", 32'(out_illegal), 32'h0);
    chk("reset_sticky", 32'(sticky_ovf), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven directed vectors
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].y, tbl[i].sel, tbl[i].fl, tbl[i].ordy, 1'b0);
      tick();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].cnt != DEPTH));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_y", i), out_y, tbl[i].oy);
      chk($sformatf("tbl%0d_out_flags", i), 32'(out_flags), 32'(tbl[i].of));
      chk($sformatf("tbl%0d_out_illegal", i), 32'(out_illegal), 32'(tbl[i].ill));
      chk($sformatf("tbl%0d_last_flags", i), 32'(last_flags), 32'(tbl[i].lf));
    end

    // Continuous push+pop at occupancy 1 across pointer wrap
    drive(1'b1, 32'h100, 4'b0010, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("stream_prime_count", 32'(count), 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h101 + 32'(i), 4'b0010, 4'(i), 1'b1, 1'b0);
      tick();
      chk($sformatf("stream%0d_count", i), 32'(count), 32'h1);
      chk($sformatf("stream%0d_out_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("stream%0d_out_y", i), out_y, 32'h101 + 32'(i));
    end

    // Fill to 3 then assert reset asynchronously between clock edges
    drive(1'b1, 32'h200, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h201, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("midreset_pre_count", 32'(count), 32'h3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_count", 32'(count), 32'h0);
    chk("midreset_out_valid", 32'(out_valid), 32'h0);
    chk("midreset_in_ready", 32'(in_ready), 32'h1);
    chk("midreset_out_y", out_y, 32'h0);
    chk("midreset_last_flags", 32'(last_flags), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: set, hold, clear, and set-beats-clear
    drive(1'b1, 32'h1, 4'b0000, 4'b0001, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h2, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    chk("sticky_set_hold", 32'(sticky_ovf), 32'h1);
    drive(1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    tick();
    chk("sticky_clear", 32'(sticky_ovf), 32'h0);
    drive(1'b1, 32'h3, 4'b0000, 4'b0001, 1'b1, 1'b1);
    tick();
    chk("sticky_set_wins", 32'(sticky_ovf), 32'h1);
    drive(1'b0, 32'h0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    tick();
    chk("sticky_clear2", 32'(sticky_ovf), 32'h0);
`endif

    // Randomized run against the queue model
    do_reset();
    mq.delete();
    lf_m = 4'h0;
    st_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic        iv, ordy, clr, pu, po;
      logic [31:0] y;
      logic [3:0]  sel, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      y    = $urandom;
      sel  = 4'($urandom_range(0, 15));
      fl   = 4'($urandom_range(0, 15));
      drive(iv, y, sel, fl, ordy, clr);
      pu = iv && (mq.size() < DEPTH);
      po = ordy && (mq.size() > 0);
      tick();
      if (po) begin
        void'(mq.pop_front());
      end
      if (pu) begin
        mq.push_back('{y, sel, fl});
        lf_m = fl;
      end
      if (pu && fl[0]) begin
        st_m = 1'b1;
      end else if (clr) begin
        st_m = 1'b0;
      end
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Registered output stage directly downstream of the combinational 32-bit ALU.
- Captures Y, the op select and the four status flags {Cout, Negative, Zero, Overflow} with a valid/ready handshake.
- Buffers up to DEPTH results in order and presents them to the writeback/consumer.
- Holds a "last flags" status register for branch/condition logic.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result on Y/flags is valid this cycle
- in_ready  out  1  FIFO can accept; equals not-full
- in_y  in  32  ALU Y
- in_sel  in  4  ALU sel that produced in_y
- in_cout, in_neg, in_zero, in_ovf  in  1 each  ALU flags
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes head this cycle
- out_y  out  32  head result
- out_sel  out  4  head op code
- out_flags  out  4  head flags packed {cout,neg,zero,ovf}
- out_illegal  out  1  head entry was produced by an unsupported sel (1001, 1110, 1111)
- last_flags  out  4  flags of most recently accepted entry
- count  out  AW+1  current occupancy

Behaviour:
- Reset (async assert, sync release): rd_ptr = 0, wr_ptr = 0, count = 0, out_valid = 0, in_ready = 1, last_flags = 0. out_y, out_sel, out_flags and out_illegal read as 0 while empty. Storage array is not reset. Reset mid-transfer drops all entries.
- Push: in_valid & in_ready at a rising edge. Writes {in_y, in_sel, flags, illegal} at wr_ptr, increments wr_ptr with wrap modulo DEPTH, updates last_flags.
- Pop: out_valid & out_ready at a rising edge. Increments rd_ptr with wrap modulo DEPTH.
- Show-ahead: the head is driven combinationally from storage[rd_ptr].
- Latency: an entry pushed at edge N is visible on out_* with out_valid = 1 after edge N (1 cycle). Zero-cycle bypass is not allowed.
- Occupancy: count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Full (count == DEPTH): in_ready = 0; a same-cycle pop does not re-open in_ready. No ready-to-ready combinational path.
  - Empty: out_valid = 0 and out_ready is ignored.
  - Push with pop when count == 1: entry handed over, count stays 1, out_valid stays high.
- illegal = 1 when in_sel is 1001, 1110 or 1111. Such entries are still stored and in order. Their Y and flags are taken as given.
- in_valid while in_ready = 0: nothing is written and the upstream must hold its data (standard valid/ready). No internal state machine beyond pointers and count: states are EMPTY (count 0), PARTIAL, FULL (count DEPTH).

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- When defined:
  - Extra ports: clr_sticky (in, 1) and sticky_ovf (out, 1).
  - sticky_ovf resets to 0 and is set on any push with in_ovf = 1.
  - clr_sticky clears it; if clr_sticky and an overflowing push occur in the same cycle, sticky_ovf = 1 (set wins).
- When undefined: neither port nor register exists; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Flag bit index constants (FLAG_COUT = 3, FLAG_NEG = 2, FLAG_ZERO = 1, FLAG_OVF = 0).
  - 4-bit op code constants for sel 0000–1101.
  - Function is_illegal_sel.
  - Packed entry typedef {y[31:0], sel[3:0], flags[3:0], illegal}.
- One natural sub-module: alu_fifo_mem, a DEPTH x entry register array with one write port and one async read port. Pointer and count control stay in the top.

Test Plan:
- Reset then single push (Y = 0x0000_0005, sel = 0110, flags = 0000) -> out_valid after 1 edge, out_y = 5, count = 1, last_flags = 0000; pop -> count = 0, out_valid = 0.
- Push 4 entries (Y = 1,2,3,4) with out_ready = 0 -> in_ready = 0 after 4th, count = 4; 5th in_valid is ignored; drain gives 1,2,3,4 in order.
- Full plus simultaneous pop and in_valid -> pop occurs, push refused, count = 3; next cycle push accepted, count = 4.
- Continuous push+pop for 10 cycles at count = 1 -> count stays 1, data in order across pointer wrap (wr_ptr 3->0).
- Push with sel = 1001 -> out_illegal = 1; sel = 1101 -> out_illegal = 0.
- Assert rst_n low mid-stream with count = 3 -> count = 0, out_valid = 0, in_ready = 1 immediately (async).
- ALU_STICKY_OVF_EN: push with ovf = 1, then ovf = 0 -> sticky_ovf = 1; clr_sticky -> 0; clr_sticky with an ovf push in the same cycle -> 1.
